hbf_dec: RTL and testbench

Parametrised half-band decimate-by-2 filter for the DSM decimation chain; successor to the fixed single-channel half-band stages. It generalises data width, tap count, output width and channel count (round-robin TDM), and adds rounding, channel tagging and an overflow indication. It accepts one sample per enabled cycle at full clock rate and emits one output per channel per two input samples of that channel.

---
 rtl/hbf_pkg.sv | 19 +
 rtl/hbf_sym_mac.sv | 119 +++++++++++
 rtl/hbf_dec.sv | 76 +++++++
 tb/tb_hbf_dec.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hbf_pkg.sv
// Shared constants and helpers for the half-band decimator: default 7-tap Q17
// coefficient set, accumulator width and rounding constant.
package hbf_pkg;

  localparam int HBF_NTAPS_DEF  = 7;
  localparam int HBF_CW_DEF     = 18;
  localparam int HBF_CENTER_DEF = 65536;
  // Side coefficients, outermost first: Q17 of [-1, 9]/32
  localparam logic [2*HBF_CW_DEF-1:0] HBF_COEF_DEF = {-18'sd4096, 18'sd36864};

  function automatic int hbf_acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + 1 + $clog2((ntaps + 1) / 4 + 1);
  endfunction

  function automatic logic [127:0] hbf_round_const(input int shift);
    return 128'(1) << (shift - 1);
  endfunction

endpackage

// File: rtl/hbf_sym_mac.sv
// Symmetric half-band datapath: pre-add, multiply, sum/round/clamp, 3 stages, no stall.
// Define HBF_DEC_SAT_EN to clamp to OW bits and flag ovf; otherwise the result wraps.
module hbf_sym_mac
  import hbf_pkg::*;
#(
  parameter int DW     = 33,
  parameter int OW     = 33,
  parameter int NTAPS  = 7,
  parameter int CW     = 18,
  parameter logic [((NTAPS+1)/4)*CW-1:0] COEF = HBF_COEF_DEF,
  parameter int CENTER = 65536,
  parameter int SHIFT  = 17,
  parameter int CHW    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld,
  input  logic [CHW-1:0]        ch,
  input  logic signed [DW-1:0]  win [NTAPS],
  output logic signed [OW-1:0]  out,
  output logic                  valid_out,
  output logic [CHW-1:0]        ch_out,
  output logic                  ovf
);

  localparam int NP = (NTAPS + 1) / 4;
  localparam int CI = (NTAPS - 1) / 2;
  localparam int PW = DW + CW + 1;
  localparam int AW = hbf_acc_width(DW, CW, NTAPS);
  localparam int RW = AW + 1 - SHIFT;
  localparam logic [127:0] RND_FULL = hbf_round_const(SHIFT);
  localparam logic signed [AW:0] RND = (AW+1)'(RND_FULL);
  localparam logic signed [CW-1:0] CCOEF = CW'(CENTER);

  function automatic logic signed [CW-1:0] coef_at(input int p);
    return COEF[(NP-p)*CW-1 -: CW];
  endfunction

  logic                      v1, v2;
  logic [CHW-1:0]            ch1, ch2;
  logic signed [DW:0]        pre [NP];
  logic signed [DW-1:0]      ctr;
  logic signed [PW-1:0]      prod [NP];
  logic signed [DW+CW-1:0]   cprod;

  logic signed [AW-1:0]      acc;
  logic signed [AW:0]        rnd;
  logic signed [RW-1:0]      res;
  logic signed [OW-1:0]      res_o;
  logic                      res_ovf;

`ifdef HBF_DEC_SAT_EN
  localparam int EW = ((RW > OW) ? RW : OW) + 1;
  localparam logic signed [EW-1:0] OMAX = (EW'(1) <<< (OW-1)) - EW'(1);
  localparam logic signed [EW-1:0] OMIN = -(EW'(1) <<< (OW-1));
  logic signed [EW-1:0] res_x;
`endif

  always_comb begin
    acc = AW'(cprod);
    for (int p = 0; p < NP; p++) acc = acc + AW'(prod[p]);
    rnd = (AW+1)'(acc) + RND;
    res = RW'(rnd >>> SHIFT);
    res_o   = OW'(res);
    res_ovf = 1'b0;
`ifdef HBF_DEC_SAT_EN
    res_x = EW'(res);
    if (res_x > OMAX) begin
      res_o   = OW'(OMAX);
      res_ovf = 1'b1;
    end else if (res_x < OMIN) begin
      res_o   = OW'(OMIN);
      res_ovf = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      ch1       <= '0;
      ch2       <= '0;
      ch_out    <= '0;
      out       <= '0;
      ovf       <= 1'b0;
      ctr       <= '0;
      cprod     <= '0;
      for (int p = 0; p < NP; p++) begin
        pre[p]  <= '0;
        prod[p] <= '0;
      end
    end else begin
      v1        <= vld;
      v2        <= v1;
      valid_out <= v2;
      // Data registers only move with a valid token so gaps leave them intact.
      if (vld) begin
        ch1 <= ch;
        ctr <= win[CI];
        for (int p = 0; p < NP; p++)
          pre[p] <= (DW+1)'(win[2*p]) + (DW+1)'(win[NTAPS-1-2*p]);
      end
      if (v1) begin
        ch2   <= ch1;
        cprod <= (DW+CW)'(ctr) * (DW+CW)'(CCOEF);
        for (int p = 0; p < NP; p++)
          prod[p] <= PW'(pre[p]) * PW'(coef_at(p));
      end
      if (v2) begin
        out    <= res_o;
        ovf    <= res_ovf;
        ch_out <= ch2;
      end
    end
  end

endmodule

// File: rtl/hbf_dec.sv
// Half-band decimate-by-2 over NCH round-robin channels; output 3 cycles after each odd sample.
// Optional HBF_DEC_SAT_EN selects output clamping with ovf instead of two's-complement wrap.
module hbf_dec
  import hbf_pkg::*;
#(
  parameter int DW     = 33,
  parameter int OW     = 33,
  parameter int NTAPS  = 7,
  parameter int CW     = 18,
  parameter logic [((NTAPS+1)/4)*CW-1:0] COEF = HBF_COEF_DEF,
  parameter int CENTER = 65536,
  parameter int SHIFT  = 17,
  parameter int NCH    = 1,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [DW-1:0]  in,
  input  logic                  valid_in,
  output logic signed [OW-1:0]  out,
  output logic                  valid_out,
  output logic [CHW-1:0]        ch_out,
  output logic                  ovf
);

  logic [CHW-1:0]        cc, f_ch;
  logic                  phase, f_vld, last;
  logic signed [DW-1:0]  dl  [NCH][NTAPS];
  logic signed [DW-1:0]  win [NTAPS];

  assign last = (cc == CHW'(NCH - 1));

  // One phase bit serves all channels: every channel sees the same j parity per round.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc    <= '0;
      phase <= 1'b0;
      f_vld <= 1'b0;
      f_ch  <= '0;
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < NTAPS; i++)
          dl[c][i] <= '0;
    end else begin
      f_vld <= valid_in && phase;
      if (valid_in) begin
        f_ch      <= cc;
        dl[cc][0] <= in;
        for (int i = 1; i < NTAPS; i++) dl[cc][i] <= dl[cc][i-1];
        cc <= last ? '0 : cc + 1'b1;
        if (last) phase <= ~phase;
      end
    end
  end

  // The fired channel's line is read one cycle later; a new sample can only land
  // on it at that same edge, so the pre-add still sees the complete window.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) win[i] = dl[f_ch][i];
  end

  hbf_sym_mac #(
    .DW(DW), .OW(OW), .NTAPS(NTAPS), .CW(CW), .COEF(COEF),
    .CENTER(CENTER), .SHIFT(SHIFT), .CHW(CHW)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .vld       (f_vld),
    .ch        (f_ch),
    .win       (win),
    .out       (out),
    .valid_out (valid_out),
    .ch_out    (ch_out),
    .ovf       (ovf)
  );

endmodule

// File: tb/tb_hbf_dec.sv
// Scoreboard bench: dut_a (defaults, NCH=1) and dut_b (OW=16, NCH=2) share one input stream,
// each checked against a direct convolution model of y[m] = sum h[i]*x[2m+1-i].
module tb_hbf_dec;

  logic clk = 1'b0;
  logic rst;
  logic signed [32:0] din;
  logic vin;
  logic signed [32:0] out_a;
  logic vout_a, ovf_a;
  logic [0:0] ch_a;
  logic signed [15:0] out_b;
  logic vout_b, ovf_b;
  logic [0:0] ch_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hbf_dec #(.NCH(1)) dut_a (
    .clk(clk), .rst(rst), .in(din), .valid_in(vin),
    .out(out_a), .valid_out(vout_a), .ch_out(ch_a), .ovf(ovf_a)
  );

  hbf_dec #(.OW(16), .NCH(2)) dut_b (
    .clk(clk), .rst(rst), .in(din), .valid_in(vin),
    .out(out_b), .valid_out(vout_b), .ch_out(ch_b), .ovf(ovf_b)
  );

`ifdef HBF_DEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct { int due; int ch; longint y; bit ov; } exp_t;
  exp_t   eq [2][$];
  longint hq [2][2][$];
  int     mcc [2];
  longint h [7] = '{-4096, 0, 36864, 65536, 36864, 0, -4096};

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint fold(input longint r, input int ow, output bit ov);
    longint mx, mn, m, v;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    m  = longint'(1) <<< ow;
    ov = 1'b0;
    if (SAT) begin
      if (r > mx) begin ov = 1'b1; return mx; end
      if (r < mn) begin ov = 1'b1; return mn; end
      return r;
    end
    v = r & (m - 1);
    if (v > mx) v = v - m;
    return v;
  endfunction

  task automatic model(input longint x);
    int nch, ow, c, j;
    longint acc;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      nch = (d == 0) ? 1 : 2;
      ow  = (d == 0) ? 33 : 16;
      c   = mcc[d];
      hq[d][c].push_back(x);
      j = hq[d][c].size() - 1;
      if (j % 2 == 1) begin
        acc = 0;
        for (int i = 0; i < 7; i++)
          if (j - i >= 0) acc += h[i] * hq[d][c][j-i];
        e.due = cyc + 4;
        e.ch  = c;
        e.y   = fold((acc + 65536) >>> 17, ow, e.ov);
        eq[d].push_back(e);
      end
      mcc[d] = (c + 1) % nch;
    end
  endtask

  task automatic drive(input bit v, input longint x);
    vin = v;
    din = x[32:0];
    if (v) model(x);
    @(posedge clk); #1;
  endtask

  function automatic longint rnd_sample();
    logic [63:0] t;
    logic signed [32:0] s;
    if ($urandom_range(0, 1) == 1) return longint'($urandom_range(0, 80000)) - 40000;
    t = {$urandom(), $urandom()};
    s = t[32:0];
    return s;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_out_a"}, out_a, 0);
    check({tag, "_vld_a"}, vout_a, 0);
    check({tag, "_ch_a"}, ch_a, 0);
    check({tag, "_ovf_a"}, ovf_a, 0);
    check({tag, "_out_b"}, out_b, 0);
    check({tag, "_vld_b"}, vout_b, 0);
    check({tag, "_ch_b"}, ch_b, 0);
    check({tag, "_ovf_b"}, ovf_b, 0);
  endtask

  // Reset takes effect at the next edge: anything due after the current cycle is dropped.
  task automatic apply_reset();
    rst = 1'b1;
    vin = 1'b1;
    for (int d = 0; d < 2; d++) begin
      while (eq[d].size() > 0 && eq[d][eq[d].size()-1].due > cyc) void'(eq[d].pop_back());
      for (int c = 0; c < 2; c++) hq[d][c].delete();
      mcc[d] = 0;
    end
    @(posedge clk); #1;
    check_idle("midrst");
    rst = 1'b0;
  endtask

  task automatic pop_cmp(input int d, input longint y, input int ch, input bit ov);
    exp_t e;
    if (eq[d].size() == 0) begin
      total++;
      bad++;
      $display("FAIL spurious_out dut%0d: got out=%0d, required no valid_out (cycle %0d)", d, y, cyc);
      return;
    end
    e = eq[d].pop_front();
    check($sformatf("latency_dut%0d", d), cyc, e.due);
    check($sformatf("out_dut%0d", d), y, e.y);
    check($sformatf("ch_dut%0d", d), ch, e.ch);
    check($sformatf("ovf_dut%0d", d), ov, e.ov);
  endtask

  always @(negedge clk) begin
    if (vout_a) pop_cmp(0, out_a, int'(ch_a), ovf_a);
    if (vout_b) pop_cmp(1, out_b, int'(ch_b), ovf_b);
  end

  initial begin
    rst = 1'b1;
    vin = 1'b0;
    din = '0;
    mcc[0] = 0;
    mcc[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    drive(1, 0);
    drive(1, 32000);
    repeat (10) drive(1, 0);
    drive(1, 32000);
    repeat (10) drive(1, 0);
    repeat (24) drive(1, 1000);
    repeat (24) drive(1, 40000);
    repeat (24) drive(1, -40000);

    for (int n = 0; n < 400; n++) drive($urandom_range(0, 2) != 0, rnd_sample());
    for (int n = 0; n < 7; n++) drive(1, rnd_sample());

    apply_reset();
    drive(1, 0);
    drive(1, 32000);
    repeat (10) drive(1, 0);
    for (int n = 0; n < 300; n++) drive(1, rnd_sample());

    repeat (8) drive(0, rnd_sample());
    check("drain_dut0", eq[0].size(), 0);
    check("drain_dut1", eq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
